// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a FIFO with a registered (1-cycle) read port and
// re-presents the words as a valid/ready stream. A small credit-controlled
// skid buffer hides the read latency so one word per cycle can be sustained.
// Optional build macro: RD_UNDERFLOW_CHK_EN -- when defined, a read that comes
// back with underflow is discarded and a sticky err_underflow flag is raised;
// when undefined, underflow is ignored and err_underflow is tied low.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           empty,
  input  logic                           underflow,
  input  logic [FIFO_WIDTH-1:0]          data_out,
  output logic                           rd_en,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [FIFO_WIDTH-1:0]          m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] level,
  output logic                           busy,
  output logic                           err_underflow
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [LW:0]   DEPTH_CMP = (LW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_IDX  = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   inflight_q;
  logic [PW-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]          rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]          level_reg, level_next;
  logic [LW:0]            committed;
  logic                   capture_ok;
  logic                   push;
  logic                   pop;

  logic [BUF_DEPTH-1:0][FIFO_WIDTH-1:0] entries;

  // Words already held plus the one still coming back from the FIFO must
  // never exceed the buffer, so a read is only issued when a slot is free
  // for it. m_ready is deliberately absent here: the credit only frees on the
  // cycle after a pop, which keeps the consumer out of the rd_en timing path.
  assign committed = {1'b0, level_reg} + {{LW{1'b0}}, inflight_q};
  assign rd_en     = (state_reg == ST_STREAM) && enable && !flush && !empty &&
                     (committed < DEPTH_CMP);

  assign m_valid    = (level_reg != '0) && (state_reg != ST_FLUSH);
  assign pop        = m_valid && m_ready;
  assign capture_ok = inflight_q && (state_reg != ST_FLUSH) && !flush;
  assign m_data     = entries[rd_ptr_reg];
  assign level      = level_reg;
  assign busy       = (state_reg != ST_IDLE);

`ifdef RD_UNDERFLOW_CHK_EN
  logic err_reg;

  assign push          = capture_ok && !underflow;
  assign err_underflow = err_reg;

  // Sticky protocol error: once a read returns with underflow, stay set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (inflight_q && underflow) begin
      err_reg <= 1'b1;
    end
  end
`else
  logic unused_underflow;

  assign push             = capture_ok;
  assign unused_underflow = underflow;
  assign err_underflow    = 1'b0;
`endif

  // One register per skid entry; the entry addressed by wr_ptr takes the returning word.
  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [FIFO_WIDTH-1:0] entry_reg;

      // Capture the FIFO word into this slot when it is the write target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= data_out;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // State register plus the one-deep record of an outstanding FIFO read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_reg  <= state_next;
      inflight_q <= rd_en;
    end
  end

  // Next-state logic; flush overrides everything and FLUSH waits out the in-flight read.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_FLUSH;
    end else begin
      case (state_reg)
        ST_IDLE:   if (enable)      state_next = ST_STREAM;
        ST_STREAM: if (!enable)     state_next = ST_IDLE;
        ST_FLUSH:  if (!inflight_q) state_next = ST_IDLE;
        default:                    state_next = ST_IDLE;
      endcase
    end
  end

  // Circular-buffer bookkeeping; pointers wrap by compare since depth need not be a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_next = level_reg + LW'(1);
        2'b01:   level_next = level_reg - LW'(1);
        default: level_next = level_reg;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Self-checking bench for fifo_rd_streamer. A queue-based FIFO model feeds the
// DUT with one-cycle read latency; a scoreboard of words read but not yet
// delivered (minus words lost to flush/underflow/reset) gives expected data.
module tb_fifo_rd_streamer;

  localparam int W  = 16;
  localparam int D  = 3;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          empty = 1'b1;
  logic          underflow = 1'b0;
  logic [W-1:0]  data_out = '0;
  logic          rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic [LW-1:0] level;
  logic          busy;
  logic          err_underflow;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.FIFO_WIDTH(W), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .empty(empty),
    .underflow(underflow), .data_out(data_out), .rd_en(rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .level(level), .busy(busy),
    .err_underflow(err_underflow)
  );

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit           pending_rd, drop_next, uf_arm, err_exp, prev_stall, prev_flush;
  logic [W-1:0] prev_data;
  bit           drv_enable, drv_flush, drv_ready;
  int           n_checks, n_pass, delivered, cyc;
  int           rd_cnt, first_rd, last_rd, mv_cnt, first_mv, last_mv, lvl_max, base_del, fell_at;
  bit           hit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic load_seq(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
  endtask

  // One clock cycle: drive inputs just after posedge, sample/check at negedge.
  task automatic cycle();
    bit           uf_now, keep;
    logic [W-1:0] w;
    @(posedge clk);
    #1;
    cyc++;
    uf_now    = 1'b0;
    underflow = 1'b0;
    if (pending_rd) begin
      w = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
      data_out = w;
      if (uf_arm) begin
        underflow = 1'b1;
        uf_now    = 1'b1;
        uf_arm    = 1'b0;
      end
      keep = !drop_next;
`ifdef RD_UNDERFLOW_CHK_EN
      if (uf_now) keep = 1'b0;
`endif
      if (keep) exp_q.push_back(w);
    end else begin
      data_out = W'($urandom);
    end
    drop_next = 1'b0;
    empty     = (fifo_q.size() == 0);
    enable    = drv_enable;
    flush     = drv_flush;
    m_ready   = drv_ready;
    @(negedge clk);
    check_eq("rd_en_gate", {31'd0, rd_en && (!enable || empty)}, 32'd0);
    check_eq("level_bound", {31'd0, (int'(level) > D)}, 32'd0);
    check_eq("err_underflow", {31'd0, err_underflow}, {31'd0, err_exp});
    if (prev_stall && !prev_flush) begin
      check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
      check_eq("hold_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", {31'd0, m_valid}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check_eq("data", {16'd0, m_data}, {16'd0, w});
      end
      delivered++;
      $display("xfer %0d: cycle %0d data=0x%04h level=%0d", delivered, cyc, m_data, level);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_flush = flush;
    pending_rd = rd_en;
`ifdef RD_UNDERFLOW_CHK_EN
    if (uf_now) err_exp = 1'b1;
`endif
    if (flush) begin
      exp_q.delete();
      drop_next = 1'b1;
    end
  endtask

  // Asynchronous reset pulse issued between edges; outputs must clear with no clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_m_data", {16'd0, m_data}, 32'd0);
    check_eq("rst_level", {30'd0, level}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err_underflow}, 32'd0);
    exp_q.delete();
    pending_rd = 1'b0;
    drop_next  = 1'b0;
    uf_arm     = 1'b0;
    err_exp    = 1'b0;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    drv_enable = 1'b0; drv_flush = 1'b0; drv_ready = 1'b0;
    apply_reset();

    // 1: eight pre-loaded words, full throughput
    load_seq(8, 16'h0001);
    drv_enable = 1'b1; drv_ready = 1'b1;
    rd_cnt = 0; mv_cnt = 0; first_rd = -1; first_mv = -1; lvl_max = 0; base_del = delivered;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (rd_en) begin rd_cnt++; if (first_rd < 0) first_rd = cyc; last_rd = cyc; end
      if (m_valid) begin mv_cnt++; if (first_mv < 0) first_mv = cyc; last_mv = cyc; end
      if (int'(level) > lvl_max) lvl_max = int'(level);
    end
    check_eq("t1_reads", rd_cnt, 8);
    check_eq("t1_reads_contig", last_rd - first_rd + 1, 8);
    check_eq("t1_valid_cycles", mv_cnt, 8);
    check_eq("t1_valid_contig", last_mv - first_mv + 1, 8);
    check_eq("t1_latency", first_mv - first_rd, 2);
    check_eq("t1_level_max_ok", {31'd0, lvl_max <= 2}, 32'd1);
    check_eq("t1_delivered", delivered - base_del, 8);

    // 2: consumer stalled -> exactly D reads, then drain
    load_seq(6, 16'h0100);
    drv_ready = 1'b0; rd_cnt = 0; base_del = delivered;
    for (int i = 0; i < 10; i++) begin cycle(); if (rd_en) rd_cnt++; end
    check_eq("t2_stalled_reads", rd_cnt, 3);
    check_eq("t2_level_full", {30'd0, level}, 32'd3);
    check_eq("t2_rd_en_off", {31'd0, rd_en}, 32'd0);
    drv_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin cycle(); if (rd_en) rd_cnt++; end
    check_eq("t2_total_reads", rd_cnt, 6);
    check_eq("t2_delivered", delivered - base_del, 6);
    check_eq("t2_scoreboard_empty", exp_q.size(), 0);

    // 3: flush with a full-ish buffer and a read in flight
    load_seq(10, 16'h0200);
    drv_ready = 1'b0;
    run(6);
    check_eq("t3_level_full", {30'd0, level}, 32'd3);
    drv_ready = 1'b1; cycle();
    drv_ready = 1'b0; cycle();
    check_eq("t3_refill_read", {31'd0, rd_en}, 32'd1);
    drv_flush = 1'b1; drv_enable = 1'b0; cycle();
    drv_flush = 1'b0; cycle();
    check_eq("t3_valid_after_flush", {31'd0, m_valid}, 32'd0);
    check_eq("t3_level_after_flush", {30'd0, level}, 32'd0);
    fell_at = (busy == 1'b0) ? 1 : -1;
    for (int i = 2; i <= 4 && fell_at < 0; i++) begin
      cycle();
      if (!busy) fell_at = i;
    end
    check_eq("t3_busy_fell_in_2", {31'd0, (fell_at >= 1 && fell_at <= 2)}, 32'd1);
    drv_enable = 1'b1; drv_ready = 1'b1;
    run(14);
    check_eq("t3_fifo_drained", fifo_q.size(), 0);
    check_eq("t3_scoreboard_empty", exp_q.size(), 0);

    // 4: enable toggling every 2 cycles with random backpressure
    for (int i = 0; i < 100; i++) fifo_q.push_back(W'($urandom));
    base_del = delivered; hit = 1'b0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      drv_enable = ((k / 2) % 2) == 0;
      drv_ready  = 1'($urandom_range(0, 1));
      cycle();
      if (delivered - base_del >= 100) hit = 1'b1;
    end
    check_eq("t4_delivered", delivered - base_del, 100);
    check_eq("t4_scoreboard_empty", exp_q.size(), 0);
    check_eq("t4_fifo_drained", fifo_q.size(), 0);

    // 5: underflow reported on a read return
    drv_enable = 1'b1; drv_ready = 1'b1;
    run(4);
    load_seq(4, 16'h0500);
    uf_arm = 1'b1; base_del = delivered;
    run(12);
`ifdef RD_UNDERFLOW_CHK_EN
    check_eq("t5_delivered", delivered - base_del, 3);
    check_eq("t5_err_sticky", {31'd0, err_underflow}, 32'd1);
`else
    check_eq("t5_delivered", delivered - base_del, 4);
    check_eq("t5_err_tied", {31'd0, err_underflow}, 32'd0);
`endif

    // 6: asynchronous reset mid-burst, then clean restream
    load_seq(10, 16'h0600);
    drv_ready = 1'b0; hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cycle();
      if (level == LW'(2)) hit = 1'b1;
    end
    check_eq("t6_level_two", {30'd0, level}, 32'd2);
    apply_reset();
    drv_ready = 1'b1;
    run(20);
    check_eq("t6_fifo_drained", fifo_q.size(), 0);
    check_eq("t6_scoreboard_empty", exp_q.size(), 0);
    check_eq("t6_idle_level", {30'd0, level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
